// File: rtl/pet2001_prg_loader_pkg.sv
// Shared types and constants for the PET 2001 PRG loader.
package pet2001_prg_loader_pkg;

  localparam logic [15:0] DEF_MAX_ADDR = 16'h7FFF;
  localparam logic [7:0]  DEF_PTR_BASE = 8'h2A;

  // BASIC end pointers rewritten after a load: VARTAB, ARYTAB, STREND
  localparam int unsigned FIX_PTRS   = 3;
  localparam int unsigned FIX_WRITES = 2 * FIX_PTRS;
  localparam int unsigned FIX_IDX_W  = 3;

  typedef enum logic [3:0] {
    IDLE,
    HALT,
    GRANT,
    ADDR_LO,
    ADDR_HI,
    DATA,
    WRITE,
    FIXUP,
    RELEASE
  } state_e;

endpackage

// File: rtl/pet2001_bus_handover.sv
// CPU halt / RAM bus grant sequencing, stepped on ce_1m by the loader state.
module pet2001_bus_handover
  import pet2001_prg_loader_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   ce_1m_i,
  input  state_e state_i,
  output logic   rdy_o,
  output logic   bus_sel_o
);

  logic rdy_q, rdy_d;
  logic bus_sel_q, bus_sel_d;

  // rdy drops before bus_sel rises; bus_sel drops before rdy returns
  always_comb begin
    rdy_d     = rdy_q;
    bus_sel_d = bus_sel_q;
    if (ce_1m_i) begin
      case (state_i)
        HALT:    rdy_d = 1'b0;
        GRANT:   bus_sel_d = 1'b1;
        RELEASE: begin
          if (bus_sel_q) bus_sel_d = 1'b0;
          else           rdy_d     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // handover registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q     <= 1'b1;
      bus_sel_q <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      bus_sel_q <= bus_sel_d;
    end
  end

  assign rdy_o     = rdy_q;
  assign bus_sel_o = bus_sel_q;

endmodule

// File: rtl/pet2001_prg_loader.sv
// PRG stream loader: halts the CPU, takes the RAM bus, writes the PRG body
// at its embedded load address and hands the bus back.
// Optional macro PRG_PTR_FIXUP_EN: rewrite the BASIC end pointers after load.
module pet2001_prg_loader
  import pet2001_prg_loader_pkg::*;
#(
  parameter logic [15:0] MAX_ADDR = DEF_MAX_ADDR,
  parameter logic [7:0]  PTR_BASE = DEF_PTR_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        dl_start,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  input  logic        dl_end,
  output logic        rdy,
  output logic        bus_sel,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        busy,
  output logic        err
);

`ifdef PRG_PTR_FIXUP_EN
  localparam state_e POST_DATA = FIXUP;
`else
  localparam state_e POST_DATA = RELEASE;
`endif

  state_e      state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        dl_ready_q, dl_ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        end_q, end_d;
`ifdef PRG_PTR_FIXUP_EN
  logic [15:0]          end_addr_q, end_addr_d;
  logic [FIX_IDX_W-1:0] fix_idx_q, fix_idx_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PTR_BASE, FIX_IDX_W'(FIX_WRITES)};
`endif

  logic accept_c, end_seen_c, in_range_c;

  assign accept_c   = dl_valid & dl_ready_q;
  assign end_seen_c = dl_end | end_q;
  assign in_range_c = (ptr_q <= MAX_ADDR);

  // stream parsing, address counter and write strobes
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    end_d       = end_q;
`ifdef PRG_PTR_FIXUP_EN
    end_addr_d  = end_addr_q;
    fix_idx_d   = fix_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (dl_start) begin
          state_d = HALT;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          end_d   = 1'b0;
        end
      end
      HALT: begin
        if (dl_end) end_d = 1'b1;
        if (ce_1m) state_d = GRANT;
      end
      GRANT: begin
        if (dl_end) end_d = 1'b1;
        if (ce_1m) state_d = ADDR_LO;
      end
      ADDR_LO: begin
        if (end_seen_c) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (accept_c) begin
          ptr_d   = {ptr_q[15:8], dl_data};
          state_d = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (end_seen_c) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (accept_c) begin
          ptr_d   = {dl_data, ptr_q[7:0]};
`ifdef PRG_PTR_FIXUP_EN
          end_addr_d = {dl_data, ptr_q[7:0]};
`endif
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept_c) begin
          ram_wdata_d = dl_data;
          end_d       = dl_end;
          state_d     = WRITE;
        end else if (dl_end) begin
          state_d = POST_DATA;
        end
      end
      WRITE: begin
        if (dl_end) end_d = 1'b1;
        if (ce_1m) begin
          if (in_range_c) begin
            ram_we_d   = 1'b1;
            ram_addr_d = ptr_q;
`ifdef PRG_PTR_FIXUP_EN
            end_addr_d = ptr_q + 16'd1;
`endif
          end else begin
            err_d = 1'b1;
          end
          if (ptr_q != 16'hFFFF) ptr_d = ptr_q + 16'd1;
          state_d = end_seen_c ? POST_DATA : DATA;
        end
      end
      FIXUP: begin
`ifdef PRG_PTR_FIXUP_EN
        if (ce_1m) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = 16'(PTR_BASE) + 16'(fix_idx_q);
          ram_wdata_d = fix_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
          if (fix_idx_q == FIX_IDX_W'(FIX_WRITES - 1)) state_d = RELEASE;
          else fix_idx_d = fix_idx_q + FIX_IDX_W'(1);
        end
`else
        state_d = RELEASE;
`endif
      end
      RELEASE: begin
        if (ce_1m && !bus_sel) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PRG_PTR_FIXUP_EN
    if (state_q != FIXUP) fix_idx_d = '0;
`endif
    dl_ready_d = (state_d == ADDR_LO) || (state_d == ADDR_HI) || (state_d == DATA);
  end

  // loader registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      dl_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      end_q       <= 1'b0;
`ifdef PRG_PTR_FIXUP_EN
      end_addr_q  <= '0;
      fix_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      dl_ready_q  <= dl_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      end_q       <= end_d;
`ifdef PRG_PTR_FIXUP_EN
      end_addr_q  <= end_addr_d;
      fix_idx_q   <= fix_idx_d;
`endif
    end
  end

  pet2001_bus_handover u_handover (
    .clk       (clk),
    .reset     (reset),
    .ce_1m_i   (ce_1m),
    .state_i   (state_q),
    .rdy_o     (rdy),
    .bus_sel_o (bus_sel)
  );

  assign dl_ready  = dl_ready_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
